// File: rtl/spi_master_multi.sv
// SPI master with runtime size, chip-select, CPOL/CPHA and SCLK divider.
// One full-duplex transfer per accepted recv message; result on send.
module spi_master_multi #(
   parameter int nbits    = 34,
   parameter int ncs      = 2,
   parameter int div_bits = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     cfg_ifc_val,
   output logic                     cfg_ifc_rdy,
   input  logic [$clog2(nbits):0]   cfg_size,
   input  logic [$clog2(ncs)-1:0]   cfg_cs_addr,
   input  logic                     cfg_cpol,
   input  logic                     cfg_cpha,
   input  logic [div_bits-1:0]      cfg_div,
   input  logic                     recv_val,
   output logic                     recv_rdy,
   input  logic [nbits-1:0]         recv_msg,
   output logic                     send_val,
   input  logic                     send_rdy,
   output logic [nbits-1:0]         send_msg,
   output logic [ncs-1:0]           cs,
   output logic                     sclk,
   output logic                     mosi,
   input  logic                     miso
);

   localparam int SW = $clog2(nbits) + 1;
   localparam int CW = $clog2(ncs);
   localparam int KW = $clog2(2 * nbits) + 1;

   typedef enum logic [2:0] {
      IDLE, SETUP, XFER, HOLD, DONE
   } state_t;

   state_t state_q, state_d;

   logic [SW-1:0]       size_q;
   logic [CW-1:0]       cs_addr_q;
   logic                cpol_q;
   logic                cpha_q;
   logic [div_bits-1:0] div_q;
   logic [div_bits-1:0] hcnt_q;
   logic [KW-1:0]       k_q;
   logic [nbits-1:0]    tx_q;
   logic [nbits-1:0]    rx_q;

   logic                cfg_fire;
   logic                recv_fire;
   logic [SW-1:0]       size_in;
   logic [SW-1:0]       size_nx;
   logic                half_end;
   logic [KW-1:0]       last_k;
   logic [KW-1:0]       k_nx;
   logic                enter_k0;
   logic                enter_next;
   logic                sample;
   logic                shift_tx;
   logic [ncs-1:0]      cs_sel;

   assign cfg_fire  = cfg_ifc_val & cfg_ifc_rdy;
   assign recv_fire = recv_val & recv_rdy;
   assign size_in   = (cfg_size == '0 || cfg_size > SW'(nbits))
                    ? SW'(nbits) : cfg_size;
   assign size_nx   = cfg_fire ? size_in : size_q;
   assign half_end  = (hcnt_q == div_q);
   assign last_k    = KW'({size_q, 1'b0}) - KW'(1);
   assign k_nx      = k_q + KW'(1);
   assign enter_k0  = (state_q == SETUP) && half_end;
   assign enter_next = (state_q == XFER) && half_end
                     && (k_q != last_k);
   // Leading edges open even half-periods, trailing edges odd ones.
   assign sample    = (enter_k0 && !cpha_q)
                    || (enter_next && (k_nx[0] == cpha_q));
   assign shift_tx  = enter_next && (k_nx[0] != cpha_q);
   assign send_msg  = rx_q;

   // Decode the registered address into a one-hot active-low select.
   always_comb begin
      cs_sel = '1;
      for (int i = 0; i < ncs; i++)
         cs_sel[i] = (cs_addr_q != CW'(i));
   end

   // State register.
   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else       state_q <= state_d;
   end

   // Next-state logic and pin/handshake outputs.
   always_comb begin
      state_d     = state_q;
      cfg_ifc_rdy = 1'b0;
      recv_rdy    = 1'b0;
      send_val    = 1'b0;
      cs          = '1;
      sclk        = cpol_q;
      mosi        = 1'b0;
      unique case (state_q)
         IDLE: begin
            cfg_ifc_rdy = 1'b1;
            recv_rdy    = 1'b1;
            if (recv_fire) state_d = SETUP;
         end
         SETUP: begin
            cs   = cs_sel;
            mosi = cpha_q ? 1'b0 : tx_q[nbits-1];
            if (half_end) state_d = XFER;
         end
         XFER: begin
            cs   = cs_sel;
            sclk = cpol_q ^ !k_q[0];
            mosi = tx_q[nbits-1];
            if (half_end && k_q == last_k) state_d = HOLD;
         end
         HOLD: begin
            cs = cs_sel;
            if (half_end) state_d = DONE;
         end
         DONE: begin
            send_val = 1'b1;
            if (send_rdy) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Config registers, timing counters and shift registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         size_q    <= SW'(nbits);
         cs_addr_q <= '0;
         cpol_q    <= 1'b0;
         cpha_q    <= 1'b0;
         div_q     <= '0;
         hcnt_q    <= '0;
         k_q       <= '0;
         tx_q      <= '0;
         rx_q      <= '0;
      end else begin
         if (cfg_fire) begin
            size_q    <= size_in;
            cs_addr_q <= cfg_cs_addr;
            cpol_q    <= cfg_cpol;
            cpha_q    <= cfg_cpha;
            div_q     <= cfg_div;
         end
         if (recv_fire) begin
            tx_q   <= recv_msg << (SW'(nbits) - size_nx);
            rx_q   <= '0;
            hcnt_q <= '0;
            k_q    <= '0;
         end else begin
            if (state_q == SETUP || state_q == XFER
                || state_q == HOLD)
               hcnt_q <= half_end ? '0 : hcnt_q + div_bits'(1);
            if (enter_next) k_q <= k_nx;
            if (shift_tx)   tx_q <= tx_q << 1;
            if (sample)     rx_q <= {rx_q[nbits-2:0], miso};
         end
      end
   end

endmodule

// File: tb/tb_spi_master_multi.sv
// Directed bench for spi_master_multi (nbits=8, ncs=4).
// Loopback or fixed miso; latency, edges, cs and data checked.
module tb_spi_master_multi;

   logic       clk = 1'b0;
   logic       reset;
   logic       cfg_ifc_val;
   logic       cfg_ifc_rdy;
   logic [3:0] cfg_size;
   logic [1:0] cfg_cs_addr;
   logic       cfg_cpol;
   logic       cfg_cpha;
   logic [7:0] cfg_div;
   logic       recv_val;
   logic       recv_rdy;
   logic [7:0] recv_msg;
   logic       send_val;
   logic       send_rdy;
   logic [7:0] send_msg;
   logic [3:0] cs;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       loop;
   logic       miso_fix;

   int tests = 0;
   int fails = 0;

   int         lat, edges, mhi, n;
   logic [3:0] cs_and;
   logic       sclk1;
   logic [7:0] held;
   logic       ok;

   spi_master_multi #(.nbits(8), .ncs(4), .div_bits(8)) dut (
      .clk(clk), .reset(reset),
      .cfg_ifc_val(cfg_ifc_val), .cfg_ifc_rdy(cfg_ifc_rdy),
      .cfg_size(cfg_size), .cfg_cs_addr(cfg_cs_addr),
      .cfg_cpol(cfg_cpol), .cfg_cpha(cfg_cpha), .cfg_div(cfg_div),
      .recv_val(recv_val), .recv_rdy(recv_rdy), .recv_msg(recv_msg),
      .send_val(send_val), .send_rdy(send_rdy), .send_msg(send_msg),
      .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso)
   );

   always #5 clk = ~clk;

   assign miso = loop ? mosi : miso_fix;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [3:0] sz, input logic [1:0] a,
                      input logic p, input logic h,
                      input logic [7:0] d);
      cfg_size = sz; cfg_cs_addr = a; cfg_cpol = p;
      cfg_cpha = h; cfg_div = d; cfg_ifc_val = 1'b1;
      tick;
      cfg_ifc_val = 1'b0;
   endtask

   task automatic ack;
      send_rdy = 1'b1;
      tick;
      send_rdy = 1'b0;
   endtask

   // Fires one recv, then observes until send_val (bounded).
   task automatic xfer(input logic [7:0] msg, output int l,
                       output int e, output logic [3:0] ca,
                       output int mh, output logic s1);
      logic prev, idle;
      recv_msg = msg; recv_val = 1'b1;
      tick;
      recv_val = 1'b0; cfg_ifc_val = 1'b0;
      l = 1; e = 0; mh = 0; ca = 4'hF;
      s1 = sclk; prev = sclk; idle = sclk;
      while (!send_val && l < 400) begin
         ca &= cs;
         if (sclk != prev) begin
            e++;
            if (sclk != idle && mosi) mh++;
         end
         prev = sclk;
         tick;
         l++;
      end
   endtask

   initial begin
      reset = 1'b1; cfg_ifc_val = 0; cfg_size = 0; cfg_cs_addr = 0;
      cfg_cpol = 0; cfg_cpha = 0; cfg_div = 0; recv_val = 0;
      recv_msg = 0; send_rdy = 0; loop = 1; miso_fix = 0;
      tick; tick;
      chk("rst_cs", cs, 4'hF);
      chk("rst_sclk", sclk, 0);
      chk("rst_mosi", mosi, 0);
      chk("rst_send_val", send_val, 0);
      chk("rst_send_msg", send_msg, 0);
      chk("rst_recv_rdy", recv_rdy, 1);
      chk("rst_cfg_rdy", cfg_ifc_rdy, 1);
      reset = 1'b0;
      tick;

      // Mode 0, cs 2, fastest clock, loopback.
      cfg(4'd8, 2'd2, 0, 0, 8'd0);
      xfer(8'hA5, lat, edges, cs_and, mhi, sclk1);
      chk("t1_lat", lat, 19);
      chk("t1_edges", edges, 16);
      chk("t1_cs", cs_and, 4'b1011);
      chk("t1_msg", send_msg, 8'hA5);
      ack;

      // Mode 3, div 1.
      cfg(4'd8, 2'd2, 1, 1, 8'd1);
      chk("t2_idle", sclk, 1);
      xfer(8'h3C, lat, edges, cs_and, mhi, sclk1);
      chk("t2_lat", lat, 37);
      chk("t2_edges", edges, 16);
      chk("t2_setup_sclk", sclk1, 1);
      chk("t2_msg", send_msg, 8'h3C);
      ack;

      // Short packet, miso held high.
      cfg(4'd3, 2'd0, 0, 0, 8'd0);
      loop = 0; miso_fix = 1;
      xfer(8'hFF, lat, edges, cs_and, mhi, sclk1);
      chk("t3_lat", lat, 9);
      chk("t3_edges", edges, 6);
      chk("t3_mosi_hi", mhi, 3);
      chk("t3_cs", cs_and, 4'b1110);
      chk("t3_msg", send_msg, 8'h07);

      // Backpressure on send.
      held = send_msg; ok = 1'b1;
      repeat (10) begin
         if (!(send_val && send_msg == held && !recv_rdy
               && !cfg_ifc_rdy && cs == 4'hF))
            ok = 1'b0;
         tick;
      end
      chk("t4_hold_stable", ok, 1);
      chk("t4_send_val", send_val, 1);
      ack;
      chk("t4_recv_rdy_after", recv_rdy, 1);

      // Size 0 and oversize both mean 8 bits.
      loop = 1;
      cfg(4'd0, 2'd0, 0, 0, 8'd0);
      xfer(8'h5A, lat, edges, cs_and, mhi, sclk1);
      chk("t3_sz0_lat", lat, 19);
      chk("t3_sz0_edges", edges, 16);
      chk("t3_sz0_msg", send_msg, 8'h5A);
      ack;
      cfg(4'd15, 2'd0, 0, 0, 8'd0);
      xfer(8'h81, lat, edges, cs_and, mhi, sclk1);
      chk("t3_sz15_edges", edges, 16);
      chk("t3_sz15_msg", send_msg, 8'h81);
      ack;

      // Reset in the middle of half-period 5.
      cfg(4'd3, 2'd1, 1, 1, 8'd0);
      recv_msg = 8'hF0; recv_val = 1'b1;
      tick;
      recv_val = 1'b0;
      repeat (6) tick;
      chk("t5_mid_cs", cs, 4'b1101);
      reset = 1'b1;
      tick;
      chk("t5_cs", cs, 4'hF);
      chk("t5_sclk", sclk, 0);
      chk("t5_send_val", send_val, 0);
      chk("t5_recv_rdy", recv_rdy, 1);
      reset = 1'b0;
      tick;
      chk("t5_no_send", send_val, 0);
      xfer(8'hC3, lat, edges, cs_and, mhi, sclk1);
      chk("t5_lat", lat, 19);
      chk("t5_edges", edges, 16);
      chk("t5_cs_dflt", cs_and, 4'b1110);
      chk("t5_sclk_idle", sclk1, 0);
      chk("t5_mosi_hi", mhi, 4);
      chk("t5_msg", send_msg, 8'hC3);
      ack;

      // Config and recv in the same cycle.
      cfg_size = 4'd8; cfg_cs_addr = 2'd3; cfg_cpol = 1;
      cfg_cpha = 0; cfg_div = 8'd0; cfg_ifc_val = 1'b1;
      xfer(8'h96, lat, edges, cs_and, mhi, sclk1);
      chk("t6_cs", cs_and, 4'b0111);
      chk("t6_sclk_idle", sclk1, 1);
      chk("t6_edges", edges, 16);
      chk("t6_lat", lat, 19);
      chk("t6_msg", send_msg, 8'h96);
      ack;

      // Config offered mid-transfer waits for IDLE.
      recv_msg = 8'h11; recv_val = 1'b1;
      tick;
      recv_val = 1'b0;
      tick; tick;
      cfg_size = 4'd8; cfg_cs_addr = 2'd1; cfg_cpol = 0;
      cfg_cpha = 0; cfg_div = 8'd0; cfg_ifc_val = 1'b1;
      chk("t6_cfg_rdy_xfer", cfg_ifc_rdy, 0);
      n = 0;
      while (!send_val && n < 100) begin
         tick;
         n++;
      end
      chk("t6b_send_val", send_val, 1);
      chk("t6b_old_cpol", sclk, 1);
      chk("t6b_msg", send_msg, 8'h11);
      ack;
      chk("t6b_cfg_rdy_idle", cfg_ifc_rdy, 1);
      chk("t6b_sclk_before", sclk, 1);
      tick;
      cfg_ifc_val = 1'b0;
      chk("t6b_sclk_after", sclk, 0);
      xfer(8'h42, lat, edges, cs_and, mhi, sclk1);
      chk("t6b_cs_new", cs_and, 4'b1101);
      chk("t6b_msg2", send_msg, 8'h42);
      ack;

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
